// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed data-first priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t              state, state_next;
  logic                mem_req_next, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_next;
  logic                if_ack_next, dm_ack_next;
  logic [DATA_W-1:0]   if_rdata_next, dm_rdata_next;
  logic                dm_first;
  logic                grant_dm;

`ifdef MEM_ARB_RR_EN
  logic last_dm;

  // Last-grant pointer: on a tie the port that was not granted most recently wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      last_dm <= 1'b0;
    else if (state == IDLE && (dm_req_i || if_req_i))
      last_dm <= grant_dm;
  end

  assign dm_first = ~last_dm;
`else
  assign dm_first = 1'b1;
`endif

  assign grant_dm = dm_req_i & (dm_first | ~if_req_i);
  assign stall_o  = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state       <= state_next;
      mem_req_o   <= mem_req_next;
      mem_we_o    <= mem_we_next;
      mem_addr_o  <= mem_addr_next;
      mem_wdata_o <= mem_wdata_next;
      if_ack_o    <= if_ack_next;
      dm_ack_o    <= dm_ack_next;
      if_rdata_o  <= if_rdata_next;
      dm_rdata_o  <= dm_rdata_next;
    end
  end

  // Memory fields are latched on grant and held untouched until the memory acks.
  always_comb begin
    state_next     = state;
    mem_req_next   = mem_req_o;
    mem_we_next    = mem_we_o;
    mem_addr_next  = mem_addr_o;
    mem_wdata_next = mem_wdata_o;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    if_rdata_next  = if_rdata_o;
    dm_rdata_next  = dm_rdata_o;
    unique case (state)
      IDLE: begin
        if (grant_dm) begin
          state_next     = BUSY_DM;
          mem_req_next   = 1'b1;
          mem_we_next    = dm_we_i;
          mem_addr_next  = dm_addr_i;
          mem_wdata_next = dm_wdata_i;
        end else if (if_req_i) begin
          state_next     = BUSY_IF;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr_i;
          mem_wdata_next = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ack_i) begin
          state_next    = RESP;
          mem_req_next  = 1'b0;
          mem_we_next   = 1'b0;
          if_ack_next   = 1'b1;
          if_rdata_next = mem_rdata_i;
        end
      end
      BUSY_DM: begin
        if (mem_ack_i) begin
          state_next   = RESP;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          dm_ack_next  = 1'b1;
          if (!mem_we_o)
            dm_rdata_next = mem_rdata_i;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req_i, if_ack_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_ack_o;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hDEAD_BEEF;
      32'h0000_0044: return 32'hCAFE_0001;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign mem_rdata_i = mem_data(mem_addr_o);

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} dm_job_t;

  logic [31:0] if_q[$];
  dm_job_t     dm_q[$];
  logic [31:0] g_addr[$];
  logic        g_we[$];
  int          ack_order[$];
  int          n_checks, n_fail, cycle, lat, cnt;
  int          if_acks, dm_acks, if_ack_cyc, dm_ack_cyc;
  logic [31:0] if_rd_seen, dm_rd_seen;
  logic        prev_req;

  // Reference model: one owner at a time, ack the cycle after the memory strobe, then one idle cycle.
  int          owner;
  logic        done, last_dm;
  logic        e_mem_req, e_mem_we, e_if_ack, e_dm_ack;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata;

  function automatic logic dm_wins(input logic last_was_dm);
`ifdef MEM_ARB_RR_EN
    return !last_was_dm;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= 0; done <= 1'b0; last_dm <= 1'b0;
      e_mem_req <= 1'b0; e_mem_we <= 1'b0; e_mem_addr <= '0; e_mem_wdata <= '0;
      e_if_ack <= 1'b0; e_dm_ack <= 1'b0; e_if_rdata <= '0; e_dm_rdata <= '0;
    end else begin
      e_if_ack <= 1'b0;
      e_dm_ack <= 1'b0;
      if (done) begin
        done  <= 1'b0;
        owner <= 0;
      end else if (owner == 0) begin
        if (dm_req_i && (!if_req_i || dm_wins(last_dm))) begin
          owner <= 2; last_dm <= 1'b1;
          e_mem_req <= 1'b1; e_mem_we <= dm_we_i; e_mem_addr <= dm_addr_i; e_mem_wdata <= dm_wdata_i;
        end else if (if_req_i) begin
          owner <= 1; last_dm <= 1'b0;
          e_mem_req <= 1'b1; e_mem_we <= 1'b0; e_mem_addr <= if_addr_i; e_mem_wdata <= '0;
        end
      end else if (mem_ack_i) begin
        done <= 1'b1; e_mem_req <= 1'b0; e_mem_we <= 1'b0;
        if (owner == 1) begin
          e_if_ack <= 1'b1; e_if_rdata <= mem_data(e_mem_addr);
        end else begin
          e_dm_ack <= 1'b1;
          if (!e_mem_we) e_dm_rdata <= mem_data(e_mem_addr);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // One clock: drive memory and both requesters after the edge, compare against the model at the falling edge.
  task automatic step_cycle(input bit extra_ack);
    @(posedge clk);
    #1;
    cycle++;
    if (rst) cnt = 0;
    if (mem_req_o && !prev_req) begin
      g_addr.push_back(mem_addr_o);
      g_we.push_back(mem_we_o);
    end
    prev_req = mem_req_o;
    if (if_ack_o) begin
      if_acks++; if_ack_cyc = cycle; if_rd_seen = if_rdata_o; ack_order.push_back(1);
    end
    if (dm_ack_o) begin
      dm_acks++; dm_ack_cyc = cycle; dm_rd_seen = dm_rdata_o; ack_order.push_back(2);
    end
    if (mem_ack_i) begin
      mem_ack_i = 1'b0; cnt = 0;
    end else if (mem_req_o) begin
      cnt++;
      if (cnt == lat + 1) mem_ack_i = 1'b1;
    end
    if (extra_ack) mem_ack_i = 1'b1;
    if (if_req_i && if_ack_o) begin
      if_req_i = 1'b0; void'(if_q.pop_front());
    end
    if (!if_req_i && !rst && if_q.size() > 0) begin
      if_req_i = 1'b1; if_addr_i = if_q[0];
    end
    if (dm_req_i && dm_ack_o) begin
      dm_req_i = 1'b0; void'(dm_q.pop_front());
    end
    if (!dm_req_i && !rst && dm_q.size() > 0) begin
      dm_req_i = 1'b1; dm_we_i = dm_q[0].we; dm_addr_i = dm_q[0].addr; dm_wdata_i = dm_q[0].wdata;
    end
    @(negedge clk);
    check_output("mem_req", {31'b0, mem_req_o}, {31'b0, e_mem_req});
    check_output("mem_we", {31'b0, mem_we_o}, {31'b0, e_mem_we});
    check_output("mem_addr", mem_addr_o, e_mem_addr);
    check_output("mem_wdata", mem_wdata_o, e_mem_wdata);
    check_output("if_ack", {31'b0, if_ack_o}, {31'b0, e_if_ack});
    check_output("dm_ack", {31'b0, dm_ack_o}, {31'b0, e_dm_ack});
    check_output("if_rdata", if_rdata_o, e_if_rdata);
    check_output("dm_rdata", dm_rdata_o, e_dm_rdata);
    check_output("stall", {31'b0, stall_o},
                 {31'b0, (if_req_i & ~e_if_ack) | (dm_req_i & ~e_dm_ack)});
  endtask

  task automatic wait_done(input string name);
    bit busy;
    busy = 1'b1;
    for (int i = 0; i < 200 && busy; i++) begin
      step_cycle(1'b0);
      busy = (if_q.size() > 0) || (dm_q.size() > 0) || if_req_i || dm_req_i || mem_req_o;
    end
    step_cycle(1'b0);
    check_output({name, "_timeout"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic clear_logs();
    g_addr.delete(); g_we.delete(); ack_order.delete();
  endtask

  logic [31:0] exp_addr[8];
  int          t0, acks_before;

  initial begin
    n_checks = 0; n_fail = 0; cycle = 0; lat = 0; cnt = 0; prev_req = 1'b0;
    if_acks = 0; dm_acks = 0; if_ack_cyc = 0; dm_ack_cyc = 0; if_rd_seen = '0; dm_rd_seen = '0;
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 1'b0;
    step_cycle(1'b0);
    step_cycle(1'b0);
    check_output("reset_mem_req", {31'b0, mem_req_o}, 32'd0);
    check_output("reset_if_rdata", if_rdata_o, 32'd0);
    rst = 1'b0;
    step_cycle(1'b0);

    // Lone fetch, memory answers one cycle after the request is presented.
    clear_logs(); lat = 1;
    if_q.push_back(32'h0000_0010);
    step_cycle(1'b0);
    t0 = cycle;
    wait_done("if_read");
    check_output("if_read_latency", if_ack_cyc - t0, 32'd3);
    check_output("if_read_data", if_rd_seen, 32'hDEAD_BEEF);

    // Simultaneous fetch and data write: the data port goes first.
    clear_logs(); lat = 0;
    if_q.push_back(32'h0000_0020);
    dm_q.push_back('{we: 1'b1, addr: 32'h0000_0100, wdata: 32'h1234_5678});
    step_cycle(1'b0);
    wait_done("collide");
    check_output("collide_first_addr", g_addr[0], 32'h0000_0100);
    check_output("collide_first_we", {31'b0, g_we[0]}, 32'd1);
    check_output("collide_second_addr", g_addr[1], 32'h0000_0020);
    check_output("collide_ack_first", ack_order[0], 32'd2);
    check_output("collide_ack_second", ack_order[1], 32'd1);
    check_output("write_keeps_dm_rdata", dm_rdata_o, 32'd0);

    // Both ports streaming four requests each.
    clear_logs(); lat = 0;
    for (int i = 0; i < 4; i++) begin
      dm_q.push_back('{we: 1'b0, addr: 32'h300 + 32'(4 * i), wdata: 32'h0});
      if_q.push_back(32'h400 + 32'(4 * i));
    end
`ifdef MEM_ARB_RR_EN
    exp_addr = '{32'h300, 32'h400, 32'h304, 32'h404, 32'h308, 32'h408, 32'h30C, 32'h40C};
`else
    exp_addr = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h400, 32'h404, 32'h408, 32'h40C};
`endif
    step_cycle(1'b0);
    wait_done("stream");
    check_output("stream_grants", g_addr.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("stream_grant%0d", i), g_addr[i], exp_addr[i]);

    // Reset while the data port waits on a slow memory; a late strobe must be ignored.
    clear_logs(); lat = 5;
    dm_q.push_back('{we: 1'b1, addr: 32'h0000_0200, wdata: 32'hAAAA_5555});
    for (int i = 0; i < 20 && !mem_req_o; i++) step_cycle(1'b0);
    step_cycle(1'b0);
    step_cycle(1'b0);
    acks_before = dm_acks;
    #2;
    rst = 1'b1;
    dm_q.delete(); dm_req_i = 1'b0;
    #1;
    check_output("reset_abort_mem_req", {31'b0, mem_req_o}, 32'd0);
    step_cycle(1'b0);
    rst = 1'b0;
    step_cycle(1'b0);
    step_cycle(1'b1);
    step_cycle(1'b0);
    step_cycle(1'b0);
    check_output("reset_abort_no_ack", dm_acks - acks_before, 32'd0);
    check_output("reset_abort_grants", g_addr.size(), 32'd1);

    // Spurious strobe in idle, then a normal fetch to show nothing was disturbed.
    clear_logs(); lat = 2;
    acks_before = if_acks + dm_acks;
    step_cycle(1'b1);
    step_cycle(1'b0);
    step_cycle(1'b0);
    check_output("spurious_no_ack", if_acks + dm_acks - acks_before, 32'd0);
    check_output("spurious_no_grant", g_addr.size(), 32'd0);
    if_q.push_back(32'h0000_0030);
    step_cycle(1'b0);
    t0 = cycle;
    wait_done("after_spurious");
    check_output("after_spurious_latency", if_ack_cyc - t0, 32'd4);
    check_output("after_spurious_data", if_rd_seen, 32'hA5A5_0030);

    // Data read with a four-cycle memory wait.
    clear_logs(); lat = 4;
    acks_before = dm_acks;
    dm_q.push_back('{we: 1'b0, addr: 32'h0000_0044, wdata: 32'h0});
    step_cycle(1'b0);
    t0 = cycle;
    wait_done("dm_read");
    check_output("dm_read_latency", dm_ack_cyc - t0, 32'd6);
    check_output("dm_read_data", dm_rd_seen, 32'hCAFE_0001);
    check_output("dm_read_ack_width", dm_acks - acks_before, 32'd1);
    check_output("dm_read_addr", g_addr[0], 32'h0000_0044);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of all data ports.
REQ-003 Clocking and reset SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  SHALL be the asynchronous active-high reset.
REQ-006 if_req_i  input  1  SHALL be the instruction-fetch read request, held until if_ack_o.
REQ-007 if_addr_i  input  ADDR_W  SHALL be the fetch address, stable while if_req_i is high.
REQ-008 if_ack_o  output  1  SHALL be a one-cycle fetch completion pulse.
REQ-009 if_rdata_o  output  DATA_W  SHALL be the fetch data, valid when if_ack_o is high.
REQ-010 dm_req_i  input  1  SHALL be the data-port request, held until dm_ack_o.
REQ-011 dm_we_i  input  1  SHALL select write (1) or read (0).
REQ-012 dm_addr_i  input  ADDR_W  SHALL be the data address, stable while dm_req_i is high.
REQ-013 dm_wdata_i  input  DATA_W  SHALL be the write data.
REQ-014 dm_ack_o  output  1  SHALL be a one-cycle data completion pulse.
REQ-015 dm_rdata_o  output  DATA_W  SHALL be the read data, valid when dm_ack_o is high.
REQ-016 mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  output  1/1/ADDR_W/DATA_W  SHALL form the shared single-port memory request.
REQ-017 mem_ack_i  input  1  SHALL be the memory completion strobe; mem_rdata_i  input  DATA_W  SHALL carry the read data in that cycle.
REQ-018 stall_o  output  1  SHALL be the pipeline freeze request.

Function
REQ-019 States SHALL be IDLE, BUSY_IF, BUSY_DM and RESP.
- IDLE: on a pending request, latch the grant, address, we and wdata, then go to BUSY_IF or BUSY_DM.
- BUSY_x: drive mem_req_o=1 with the latched fields.
- BUSY_x on mem_ack_i: capture mem_rdata_i and go to RESP.
- RESP: drive x_ack_o=1 for exactly one cycle, then return to IDLE.
REQ-020 Outputs mem_* and x_ack_o/x_rdata_o SHALL be registered; the mem_* fields SHALL be constant throughout a BUSY state.
REQ-021 Latency SHALL be as follows: request sampled at edge 0, mem_req_o high from cycle 1; mem_ack_i in cycle n (n>=1) gives x_ack_o in cycle n+1; minimum request-to-ack latency is 2 cycles.
REQ-022 Priority SHALL be fixed when both requests are pending in IDLE: data port wins (MEM_ARB_RR_EN undefined).
REQ-023 The requester acked in RESP SHALL NOT be regranted in the following IDLE cycle unless its req is still high at that edge.
- Its req being high during the RESP cycle is ignored.
REQ-024 In IDLE, with no pending request or when mem_ack_i arrives, mem_ack_i SHALL be ignored.
REQ-025 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
REQ-026 if_rdata_o/dm_rdata_o SHALL hold their last captured value when not acked.
- For a data write, dm_rdata_o SHALL be unchanged.
REQ-027 A requester dropping req while in BUSY SHALL NOT abort the transaction; the transaction completes and the ack is still pulsed.

Reset
REQ-028 On rst_i=1 the block SHALL asynchronously enter IDLE with all outputs 0 and all latched fields 0.
- mem_req_o, mem_we_o, if_ack_o, dm_ack_o = 0; rdata = 0; round-robin pointer = IF-last.
REQ-029 Reset mid-transaction SHALL abandon the access with no ack.
- mem_ack_i arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-030 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin.
- A last-grant register selects the port not most recently granted.
- Without the macro, the fixed data-first priority of REQ-022 applies and no pointer register exists.

Verification
REQ-031 IF read 0x0000_0010 alone, memory acks 1 cycle after mem_req_o with 0xDEAD_BEEF.
- Required: if_ack_o in cycle 3, if_rdata_o=0xDEAD_BEEF, stall_o high for cycles 0-2.
REQ-032 Both requests in the same cycle (IF 0x20; DM write 0x100 data 0x1234_5678).
- Required: mem_we_o=1, mem_addr_o=0x100 first; IF granted after dm_ack_o.
REQ-033 Under MEM_ARB_RR_EN, both ports continuously requesting for 8 transactions.
- Required: grants strictly alternate DM, IF, DM, IF...
REQ-034 rst_i pulsed while in BUSY_DM with a 5-cycle memory latency.
- Required: mem_req_o=0 immediately, no dm_ack_o, and a late mem_ack_i produces no ack.
REQ-035 Spurious mem_ack_i in IDLE.
- Required: no ack pulses and no state change.
REQ-036 DM read 0x44 with memory returning 0xCAFE_0001 after 4 cycles.
- Required: mem_* fields constant across the wait, dm_ack_o one cycle wide.
